sum_scaler: RTL and testbench

Pipelined post-adder scaling stage for the WISHBONE FFT datapath. It consumes the (inst_width+1)-bit signed sum produced by the butterfly adder and returns it to inst_width bits, either by saturation or by an arithmetic right shift by one. It uses a valid/ready handshake so backpressure from the twiddle-multiplier/memory write side is honoured. It keeps a sticky overflow flag and a saturating overflow counter for block-floating-point control software.

---
 rtl/sum_scaler.sv | 134 +++++++++++++
 tb/tb_sum_scaler.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_scaler.sv
// Two-stage post-adder scaler for the FFT butterfly: saturates or halves an (inst_width+1)-bit sum.
// Optional build macro SUM_SCALER_ROUND_EN selects round-half-up instead of truncation in shift mode.
module sum_scaler #(
    parameter int inst_width = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [inst_width:0]   in_sum,
    input  logic                  in_shift,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [inst_width-1:0] out_data,
    output logic                  out_ovf,
    output logic                  ovf_flag,
    output logic [15:0]           ovf_count,
    input  logic                  clr_ovf
);

`ifdef SUM_SCALER_ROUND_EN
    localparam logic round_bit = 1'b1;
`else
    localparam logic round_bit = 1'b0;
`endif

    localparam int tw = inst_width + 2;
    localparam logic [inst_width-1:0] sat_max = {1'b0, {(inst_width-1){1'b1}}};
    localparam logic [inst_width-1:0] sat_min = {1'b1, {(inst_width-1){1'b0}}};

    logic                s1_valid;
    logic [inst_width:0] s1_sum;
    logic                s1_shift;
    logic                s2_valid;

    logic                  s1_adv;
    logic                  s2_adv;
    logic [tw-1:0]         sum_ext;
    logic [tw-1:0]         sum_rnd;
    logic [tw-1:0]         t_val;
    logic                  t_fits;
    logic [inst_width-1:0] sat_data;
    logic                  sat_ovf;
    logic                  ovf_event;

    // Ready depends only on stage occupancy and out_ready, never on in_valid.
    assign s2_adv   = !s2_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv;

    assign out_valid = s2_valid;
    assign ovf_event = s2_adv && s1_valid && sat_ovf;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        sum_ext  = {s1_sum[inst_width], s1_sum};
        sum_rnd  = sum_ext + {{(tw-1){1'b0}}, round_bit};
        t_val    = sum_ext;
        sat_data = '0;
        sat_ovf  = 1'b0;

        if (s1_shift) begin
            t_val = {sum_rnd[tw-1], sum_rnd[tw-1:1]};
        end

        // t fits in inst_width bits only when its top three bits are identical.
        t_fits = (t_val[tw-1:inst_width-1] == 3'b000) ||
                 (t_val[tw-1:inst_width-1] == 3'b111);

        if (t_fits) begin
            sat_data = t_val[inst_width-1:0];
        end else if (!t_val[tw-1]) begin
            sat_data = sat_max;
            sat_ovf  = 1'b1;
        end else begin
            sat_data = sat_min;
            sat_ovf  = 1'b1;
        end
    end

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the S1 payload is reset too; it is only a few flops and keeps
            // X out of the saturation logic when S1 is empty.
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_shift <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_sum   <= in_sum;
                s1_shift <= in_shift;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            out_data <= '0;
            out_ovf  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data;
                out_ovf  <= sat_ovf;
            end
        end
    end

    // A clear coinciding with an event leaves the flag set and the count at one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag  <= 1'b0;
            ovf_count <= '0;
        end else begin
            if (clr_ovf) begin
                ovf_flag  <= 1'b0;
                ovf_count <= '0;
            end
            if (ovf_event) begin
                ovf_flag <= 1'b1;
                if (clr_ovf) begin
                    ovf_count <= 16'd1;
                end else if (ovf_count != 16'hFFFF) begin
                    ovf_count <= ovf_count + 16'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sum_scaler.sv
// Scoreboard bench for sum_scaler at inst_width = 8; honours SUM_SCALER_ROUND_EN like the design.
module tb_sum_scaler;

    localparam int W = 8;
`ifdef SUM_SCALER_ROUND_EN
    localparam int RND = 1;
`else
    localparam int RND = 0;
`endif

    typedef struct packed {
        logic [W-1:0] data;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W:0]   in_sum;
    logic         in_shift;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         out_ovf;
    logic         ovf_flag;
    logic [15:0]  ovf_count;
    logic         clr_ovf;

    int   errors = 0;
    int   checks = 0;
    exp_t sb[$];
    exp_t exp_head;

    sum_scaler #(.inst_width(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_shift  (in_shift),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .ovf_flag  (ovf_flag),
        .ovf_count (ovf_count),
        .clr_ovf   (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(input int s, input bit sh);
        int   t;
        exp_t e;
        t = sh ? ((s + RND) >>> 1) : s;
        if (t > 127) begin
            e.data = 8'h7F;
            e.ovf  = 1'b1;
        end else if (t < -128) begin
            e.data = 8'h80;
            e.ovf  = 1'b1;
        end else begin
            e.data = t[7:0];
            e.ovf  = 1'b0;
        end
        return e;
    endfunction

    // Output monitor: each output transfer is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got data=%0d ovf=%0b, required no output", $signed(out_data), out_ovf);
            end else begin
                exp_head = sb.pop_front();
                if (out_data !== exp_head.data || out_ovf !== exp_head.ovf) begin
                    errors++;
                    $display("FAIL output_sample: got data=%0d ovf=%0b, required data=%0d ovf=%0b",
                             $signed(out_data), out_ovf, $signed(exp_head.data), exp_head.ovf);
                end
            end
        end
    end

    // Presents one sample and returns 1 time unit after the edge that accepts it.
    task automatic send(input int s, input bit sh);
        int n;
        in_valid = 1'b1;
        in_sum   = 9'(s);
        in_shift = sh;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready=%0b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        sb.push_back(model(s, sh));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending=%0d, required 0", sb.size());
        end
    endtask

    task automatic pulse_clr();
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
    endtask

    task automatic check_counters(input string name, input logic f, input logic [15:0] c);
        checks++;
        if (ovf_flag !== f || ovf_count !== c) begin
            errors++;
            $display("FAIL %s: got flag=%0b count=%0d, required flag=%0b count=%0d", name, ovf_flag, ovf_count, f, c);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_handshake: got out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
        end
        check_counters("reset_counters", 1'b0, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // Driven in cycle k, S1 loads at the first edge, S2 at the second: visible in cycle k+2.
        send(100, 1'b0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: got out_valid=%0b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_data !== 8'd100 || out_ovf !== 1'b0) begin
            errors++;
            $display("FAIL latency_on_time: got valid=%0b data=%0d ovf=%0b, required 1/100/0", out_valid, out_data, out_ovf);
        end
        wait_drain();
    endtask

    task automatic test_saturation();
        send(200, 1'b0);
        send(-256, 1'b0);
        send(-128, 1'b0);
        send(127, 1'b0);
        wait_drain();
        check_counters("saturation_counters", 1'b1, 16'd2);
    endtask

    task automatic test_shift_round();
        pulse_clr();
        check_counters("clr_before_shift", 1'b0, 16'd0);
        send(5, 1'b1);
        send(-5, 1'b1);
        send(254, 1'b1);
        send(-256, 1'b1);
        wait_drain();
        check_counters("shift_no_ovf", 1'b0, 16'd0);
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        out_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 10; i++) send(i, 1'b0);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                out_ready = 1'b0;
                @(negedge clk);
                held = out_data;
                checks++;
                if (out_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_valid: got out_valid=%0b, required 1", out_valid);
                end
                for (int c = 0; c < 4; c++) begin
                    @(negedge clk);
                    checks++;
                    if (out_data !== held || out_valid !== 1'b1) begin
                        errors++;
                        $display("FAIL stall_stable: got data=%0d valid=%0b, required data=%0d valid=1", out_data, out_valid, held);
                    end
                end
                checks++;
                if (in_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_in_ready: got in_ready=%0b, required 0", in_ready);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        wait_drain();
    endtask

    task automatic test_ovf_bookkeeping();
        for (int i = 0; i < 65538; i++) send(200, 1'b0);
        wait_drain();
        check_counters("count_saturates", 1'b1, 16'hFFFF);
        send(-200, 1'b0);
        // S2 loads this saturated sample on the very edge the clear is sampled.
        pulse_clr();
        check_counters("clr_with_event", 1'b1, 16'd1);
        wait_drain();
        pulse_clr();
        check_counters("clr_alone", 1'b0, 16'd0);
    endtask

    task automatic test_reset_midstream();
        out_ready = 1'b0;
        send(200, 1'b0);
        send(-200, 1'b0);
        @(negedge clk);
        check_counters("pre_reset_counters", 1'b1, 16'd1);
        rst_n = 1'b0;
        #1;
        sb.delete();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_handshake: got out_valid=%0b in_ready=%0b, required 0/1", out_valid, in_ready);
        end
        check_counters("midreset_counters", 1'b0, 16'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stale_after_reset: got out_valid=%0b, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        send(-7, 1'b0);
        wait_drain();
        check_counters("post_reset_counters", 1'b0, 16'd0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_sum    = '0;
        in_shift  = 1'b0;
        out_ready = 1'b1;
        clr_ovf   = 1'b0;
        test_reset();
        test_saturation();
        test_shift_round();
        test_backpressure();
        test_ovf_bookkeeping();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
